// File: rtl/spm_chain.sv
// spm_chain: cascade of STAGES serial-parallel multipliers, y = X * A^STAGES mod 2^FRAME_LEN, LSB first.
// Optional parallel result port enabled by defining SPM_CHAIN_PAR_OUT_EN.
`timescale 1ns/1ps
module spm_chain #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             x,
  input  logic [WIDTH-1:0] a,
  output logic             y,
  output logic             y_valid,
  output logic             busy,
  output logic             done
`ifdef SPM_CHAIN_PAR_OUT_EN
  ,
  output logic [FRAME_LEN-1:0] p,
  output logic                 p_valid
`endif
);
  localparam int CW = $clog2(FRAME_LEN + STAGES + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CW-1:0] LAST    = CW'(STAGES + FRAME_LEN - 1);
  localparam logic [CW-1:0] FIRST_V = CW'(STAGES);
  localparam logic [CW-1:0] X_END   = CW'(FRAME_LEN);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_a;
  logic [STAGES-1:0] w_y;
  logic              w_run;
  logic              w_accept;
  logic              w_x0;
  logic [WIDTH-1:0]  w_coef;

  assign w_run    = r_state == RUN;
  assign w_accept = start & ~w_run;
  assign busy     = w_run;
  assign done     = w_run & (r_cnt == LAST);
  assign y_valid  = w_run & (r_cnt >= FIRST_V);
  assign y        = y_valid & w_y[STAGES-1];
  // x is live in the accept cycle and the following FRAME_LEN-1 cycles; zeros after that
  assign w_x0     = x & (w_accept | (w_run & (r_cnt < X_END)));
  // coefficient is taken straight from the port in the accept cycle, from the register afterwards
  assign w_coef   = w_accept ? a : r_a;

  // frame FSM, frame counter (cycle offset from the accepted start) and coefficient capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
    end else if (w_accept) begin
      r_state <= RUN;
      r_cnt   <= CW'(1);
      r_a     <= a;
    end else if (done) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] r_acc;
    logic             r_yk;
    logic             w_in;
    logic             w_first;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH:0]   w_sum;
    if (k == 0) begin : g_head
      assign w_in    = w_x0;
      assign w_first = w_accept;
    end else begin : g_tail
      assign w_in    = w_y[k-1];
      assign w_first = w_run & (r_cnt == CW'(k));
    end
    // the stage's first bit arrives k cycles after start; drop any leftover partial sum then
    assign w_base = w_first ? '0 : r_acc;
    assign w_add  = w_in ? w_coef : '0;
    assign w_sum  = {1'b0, w_base} + {1'b0, w_add};
    assign w_y[k] = r_yk;
    // shift-accumulate: emit the low sum bit, keep the rest as the running partial product
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_acc <= '0;
        r_yk  <= 1'b0;
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_yk  <= w_sum[0];
      end
    end
  end

`ifdef SPM_CHAIN_PAR_OUT_EN
  logic [FRAME_LEN-1:0] r_p;
  logic                 r_p_valid;
  assign p       = r_p;
  assign p_valid = r_p_valid;
  // deserializer: valid bits shift in from the top so bit i lands at position i after the frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_p       <= '0;
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= done;
      if (y_valid) r_p <= FRAME_LEN'({y, r_p} >> 1);
    end
  end
`endif
endmodule

// File: doc/spm_chain.md
SPM_CHAIN -- requirements
Module: spm_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32: parallel coefficient width, >=1.
REQ-002 SHALL have parameter STAGES, default 2: number of cascaded serial-parallel multiplier stages, >=1.
REQ-003 SHALL have parameter FRAME_LEN, default 64: serial frame length in bits, >=WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  frame-start strobe; bit 0 of x is valid in the same cycle.
REQ-007 SHALL have port x  input  1  serial multiplicand, LSB first.
REQ-008 SHALL have port a  input  WIDTH  unsigned parallel coefficient, shared by all stages.
REQ-009 SHALL have port y  output  1  serial product, LSB first.
REQ-010 SHALL have port y_valid  output  1  high when y carries a product bit.
REQ-011 SHALL have port busy  output  1  frame in progress; start is ignored while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the last product bit.

Function
REQ-013 SHALL accept start only in cycle T with busy==0, capture a into an internal coefficient register at T and ignore a changes after T.
REQ-014 SHALL sample x bit i at cycle T+i for i=0..FRAME_LEN-1 and feed 0 into stage 1 from T+FRAME_LEN until frame end.
REQ-015 SHALL treat X as a FRAME_LEN-bit unsigned value and produce P = (X * A^STAGES) mod 2^FRAME_LEN.
REQ-016 SHALL register each stage's output, so stage k's bit i appears at T+i+k and y carries P bit i at T+STAGES+i.
REQ-017 SHALL clear each stage's carry/sum state at the start of that stage's frame so no residue from a previous frame affects P.
REQ-018 SHALL drive y_valid high for cycles T+STAGES through T+STAGES+FRAME_LEN-1 and drive y=0 whenever y_valid is low.
REQ-019 SHALL drive busy high for cycles T+1 through T+STAGES+FRAME_LEN-1 via a frame counter of width ceil(log2(FRAME_LEN+STAGES+1)).
REQ-020 SHALL pulse done in cycle T+STAGES+FRAME_LEN-1, coincident with the last y_valid.
REQ-021 SHALL ignore start asserted in the done cycle; the earliest next accepted start is T+STAGES+FRAME_LEN (zero-bubble back-to-back).
REQ-022 SHALL use a two-state FSM: IDLE -> RUN on accepted start, and RUN -> IDLE after the done cycle.

Reset
REQ-023 SHALL, while rstn==0, force y, y_valid, busy and done to 0 and clear the FSM (IDLE), counter, coefficient register and all stage state.
REQ-024 SHALL abandon any frame in progress on reset mid-frame, emitting no further y_valid or done; the first start after rstn rises SHALL be accepted.

Configuration
REQ-025 SHALL, with SPM_CHAIN_PAR_OUT_EN defined, add output p (FRAME_LEN bits) and p_valid (1 bit); p collects y bits at position i and updates only on valid bits, and p_valid pulses in the cycle after done with p==P held until the next frame's first valid bit.
REQ-026 SHALL, without SPM_CHAIN_PAR_OUT_EN, omit p, p_valid and the deserializer register, with serial behaviour identical.
REQ-027 SHALL reset p to 0 and p_valid to 0 when the macro is defined.

Verification
REQ-028 SHALL cover default parameters, X=3, A=5 -> y stream 75 (0x4B) over cycles T+2..T+65, done at T+65.
REQ-029 SHALL cover X=1, A=0xFFFFFFFF -> P=0xFFFFFFFE00000001, and p equal to that value after p_valid (macro defined).
REQ-030 SHALL cover STAGES=1, X=0xFFFFFFFFFFFFFFFF, A=2 -> P=0xFFFFFFFFFFFFFFFE, with y_valid high for 64 cycles starting at T+1.
REQ-031 SHALL cover start re-asserted at T+10 and in the done cycle -> both ignored; a start at T+66 is accepted with a correct result and no residue.
REQ-032 SHALL cover a change of a at T+5 -> P still computed with the value captured at T.
REQ-033 SHALL cover rstn low at T+20 -> all outputs 0 immediately; a new frame X=7, A=3 -> P=63.
